// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate_chk_seq 2-input gate checker.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      SAMPLE,
      DONE
   } state_t;

   typedef logic [1:0] vec_t;

   localparam logic [3:0] TRUTH_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_chk_vecgen.sv
// Vector, settle and pass counters for gate_chk_seq; flags the last settle cycle
// and the final vector of the final pass.
module gate_chk_vecgen
   import gate_chk_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int PASSES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic tick,
   input  logic advance,
   input  logic clear,
   output vec_t vector,
   output logic last_settle,
   output logic last_vector
);

   localparam logic [7:0] SETTLE_LD = 8'(SETTLE);
   localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

   logic [7:0] settle_cnt;
   logic [7:0] pass_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         vector     <= 2'b00;
         settle_cnt <= 8'd0;
         pass_cnt   <= 8'd0;
      end else if (load) begin
         vector     <= 2'b00;
         settle_cnt <= SETTLE_LD;
         pass_cnt   <= 8'd0;
      end else if (advance) begin
         vector     <= vector + 2'd1;
         settle_cnt <= SETTLE_LD;
         if (vector == 2'b11)
            pass_cnt <= pass_cnt + 8'd1;
      end else if (clear) begin
         vector <= 2'b00;
      end else if (tick) begin
         settle_cnt <= settle_cnt - 8'd1;
      end
   end

   // Terminal count at 1 gives exactly SETTLE apply cycles per vector.
   assign last_settle = (settle_cnt == 8'd1);
   assign last_vector = (vector == 2'b11) && (pass_cnt == PASS_LAST);

endmodule

// File: rtl/gate_chk_seq.sv
// Clocked stimulus/response checker for a 2-input gate cell.
// Optional build macro GATE_CHK_STOP_ON_FAIL_EN ends a run at the first mismatch.
//
// state  | meaning
// IDLE   | gate inputs at 00, waiting for start
// APPLY  | current vector driven, settle counter running
// SAMPLE | dut_y compared against TRUTH[vector]
// DONE   | one-cycle done pulse, then back to IDLE
module gate_chk_seq
   import gate_chk_pkg::*;
#(
   parameter int         SETTLE = 2,
   parameter int         PASSES = 1,
   parameter int         ERRW   = 8,
   parameter logic [3:0] TRUTH  = TRUTH_NAND2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            dut_a,
   output logic            dut_b,
   input  logic            dut_y,
   output logic            busy,
   output logic            done,
   output logic            fail,
   output logic [1:0]      fail_vec,
   output logic [ERRW-1:0] err_cnt
);

   localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};
   localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

   state_t state;
   vec_t   vector;
   logic   last_settle;
   logic   last_vector;
   logic   mismatch;
   logic   stop_now;
   logic   load;
   logic   advance;

   assign mismatch = (dut_y != TRUTH[vector]);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   assign stop_now = last_vector || mismatch;
`else
   assign stop_now = last_vector;
`endif

   assign load    = (state == IDLE) && start;
   assign advance = (state == SAMPLE) && !stop_now;

   gate_chk_vecgen #(
      .SETTLE (SETTLE),
      .PASSES (PASSES)
   ) u_vecgen (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .tick        (state == APPLY),
      .advance     (advance),
      .clear       (state == DONE),
      .vector      (vector),
      .last_settle (last_settle),
      .last_vector (last_vector)
   );

   // The vector register only holds meaning while busy; outside a run the cell sees 00.
   assign dut_a = busy & vector[0];
   assign dut_b = busy & vector[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         fail     <= 1'b0;
         fail_vec <= 2'b00;
         err_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= APPLY;
                  busy     <= 1'b1;
                  fail     <= 1'b0;
                  fail_vec <= 2'b00;
                  err_cnt  <= '0;
               end
            end
            APPLY: begin
               if (last_settle)
                  state <= SAMPLE;
            end
            SAMPLE: begin
               if (mismatch) begin
                  if (err_cnt != ERR_MAX)
                     err_cnt <= err_cnt + ERR_ONE;
                  if (!fail) begin
                     fail     <= 1'b1;
                     fail_vec <= vector;
                  end
               end
               if (stop_now) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= APPLY;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_chk_seq.sv
// Directed bench for gate_chk_seq: defaults, multi-pass, narrow err_cnt and mid-run reset.
module tb_gate_chk_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   int   mode = 0;
   logic y_low = 1'b0;

   logic a0, b0, y0, busy0, done0, fail0;
   logic [1:0] fv0;
   logic [7:0] err0;
   logic a1, b1, busy1, done1, fail1;
   logic [1:0] fv1;
   logic [7:0] err1;
   logic a2, b2, busy2, done2, fail2;
   logic [1:0] fv2;
   logic [1:0] err2;

   int n_vec = 0;
   int n_err = 0;
   logic [1:0] vec_log [0:63];

   always #5 clk = ~clk;

   // 0: nand2, 1: stuck at 1, 2: stuck at 0, 3: and2
   assign y0 = (mode == 0) ? ~(a0 & b0) :
               (mode == 1) ? 1'b1 :
               (mode == 2) ? 1'b0 : (a0 & b0);

   gate_chk_seq u0 (
      .clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0), .dut_y(y0),
      .busy(busy0), .done(done0), .fail(fail0), .fail_vec(fv0), .err_cnt(err0));

   gate_chk_seq #(.PASSES(2)) u1 (
      .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_y(y_low),
      .busy(busy1), .done(done1), .fail(fail1), .fail_vec(fv1), .err_cnt(err1));

   gate_chk_seq #(.PASSES(3), .ERRW(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .dut_a(a2), .dut_b(b2), .dut_y(y_low),
      .busy(busy2), .done(done2), .fail(fail2), .fail_vec(fv2), .err_cnt(err2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int s, input logic v);
      case (s)
         0: start0 = v;
         1: start1 = v;
         default: start2 = v;
      endcase
   endtask

   function automatic logic sel_done(input int s);
      return (s == 0) ? done0 : (s == 1) ? done1 : done2;
   endfunction

   function automatic logic sel_busy(input int s);
      return (s == 0) ? busy0 : (s == 1) ? busy1 : busy2;
   endfunction

   // Returns the cycle (1 = first cycle after the start edge) in which done is seen.
   task automatic run(input int s, input int extra, output int done_cyc, output int busy_n);
      int cyc;
      @(negedge clk); set_start(s, 1'b1);
      @(negedge clk); set_start(s, 1'b0);
      cyc = 1; done_cyc = -1; busy_n = 0;
      while (cyc < 200) begin
         if (sel_done(s)) begin
            done_cyc = cyc;
            break;
         end
         if (sel_busy(s)) busy_n++;
         if (s == 0 && cyc < 64) vec_log[cyc] = {b0, a0};
         set_start(s, cyc == extra);
         @(negedge clk); cyc++;
      end
      set_start(s, 1'b0);
   endtask

   initial begin
      int dc, bn;
      logic [1:0] ev;

      repeat (3) @(negedge clk);
      check("rst_a", a0, 0);
      check("rst_b", b0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_fail", fail0, 0);
      check("rst_fvec", fv0, 0);
      check("rst_err", err0, 0);
      rst = 1'b0;

      // correct nand2, with a stray start mid-run that must be ignored
      mode = 0;
      run(0, 6, dc, bn);
      check("nand_done_cyc", dc, 13);
      check("nand_busy_cyc", bn, 12);
      check("nand_fail", fail0, 0);
      check("nand_err", err0, 0);
      for (int c = 1; c <= 12; c++) begin
         ev = 2'((c - 1) / 3);
         check($sformatf("nand_vec_c%0d", c), vec_log[c], ev);
      end
      @(negedge clk);
      check("done_pulse_clr", done0, 0);
      check("no_queued_start", busy0, 0);
      @(negedge clk);
      check("idle_hold", busy0, 0);

      mode = 1;
      run(0, -1, dc, bn);
      check("st1_done_cyc", dc, 13);
      check("st1_fail", fail0, 1);
      check("st1_fvec", fv0, 3);
      check("st1_err", err0, 1);

      mode = 0;
      run(0, -1, dc, bn);
      check("clr_fail", fail0, 0);
      check("clr_fvec", fv0, 0);
      check("clr_err", err0, 0);

      mode = 3;
      run(0, -1, dc, bn);
      check("and_fail", fail0, 1);
      check("and_fvec", fv0, 0);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      check("and_done_cyc", dc, 4);
      check("and_err", err0, 1);
`else
      check("and_done_cyc", dc, 13);
      check("and_err", err0, 4);
`endif

      run(1, -1, dc, bn);
      check("p2_fvec", fv1, 0);
      check("p2_fail", fail1, 1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      check("p2_done_cyc", dc, 4);
      check("p2_err", err1, 1);
`else
      check("p2_done_cyc", dc, 25);
      check("p2_err", err1, 6);
`endif

      run(2, -1, dc, bn);
      check("sat_fail", fail2, 1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      check("sat_done_cyc", dc, 4);
      check("sat_err", err2, 1);
`else
      check("sat_done_cyc", dc, 37);
      check("sat_err", err2, 3);
`endif

      // reset at cycle 5 of a failing run
      mode = 3;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      @(negedge clk);
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      check("pre_rst_fail", fail0, 1);
      check("pre_rst_err", err0, 1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("mid_rst_a", a0, 0);
      check("mid_rst_b", b0, 0);
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_done", done0, 0);
      check("mid_rst_fail", fail0, 0);
      check("mid_rst_fvec", fv0, 0);
      check("mid_rst_err", err0, 0);
      rst = 1'b0;
      mode = 0;
      run(0, -1, dc, bn);
      check("post_rst_done_cyc", dc, 13);
      check("post_rst_busy_cyc", bn, 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
